sd_fifo_memctl: RTL and testbench
=================================

# sd_fifo_memctl

Single-clock srdy/drdy FIFO controller that drives an external two-port memory with a registered read address (write on clock edge; read data valid combinationally after the edge that captures the read address). It sits directly upstream of that memory, generating write/read enables and addresses. It also owns a two-entry output prefetch buffer, so the one-cycle read latency is hidden and the producer interface sustains one word per cycle.

## Interface
- width, 8, data word width
- depth, 16, memory entries; any value ≥ 2, not required to be a power of two
- asz, $clog2(depth), memory address width
- usz, $clog2(depth+3), usage counter width
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-high
- c_srdy  in  1  consumer-side data valid
- c_drdy  out  1  consumer-side ready
- c_data  in  width  write data
- p_srdy  out  1  producer-side data valid
- p_drdy  in  1  producer-side ready
- p_data  out  width  head-of-FIFO data
- usage  out  usz  words held (memory + read in flight + output buffer)
- mem_wr_en  out  1  memory write enable
- mem_wr_addr  out  asz  memory write address
- mem_d_in  out  width  memory write data (equals c_data)
- mem_rd_en  out  1  memory read-address capture enable
- mem_rd_addr  out  asz  memory read address
- mem_d_out  in  width  memory read data

## Operation
- Transfers: push = c_srdy & c_drdy; pop = p_srdy & p_drdy.
- c_drdy = (mem_cnt < depth). mem_wr_en = push, mem_wr_addr = wrptr, mem_d_in = c_data.
- wrptr/rdptr wrap from depth-1 to 0 explicitly; no modulo-2^asz arithmetic.
- mem_cnt: +1 on push, -1 on read issue, unchanged when both happen.
- Read issue: mem_rd_en = (mem_cnt != 0) & (obuf_cnt + rd_pend - pop < 2). mem_rd_addr = rdptr; rdptr advances on issue.
- rd_pend is set on issue. On the next cycle, mem_d_out is written into the output buffer.
- Output buffer: 2-entry FIFO (obuf_cnt 0..2). The head drives p_data; p_srdy = (obuf_cnt != 0).
- usage = mem_cnt + rd_pend + obuf_cnt. Maximum is depth+2.
- Push and read issue on the same cycle are legal. A read is only issued against entries already counted in mem_cnt, so it never targets the address being written that cycle.
- Push, read return and pop may all occur on the same cycle. All counters update consistently.
- Reset values:
  - c_drdy=1 (follows mem_cnt=0), p_srdy=0, p_data=0, usage=0.
  - mem_wr_en=0, mem_rd_en=0, mem_rd_addr=0, mem_wr_addr=0.
  - wrptr, rdptr, mem_cnt, rd_pend and obuf_cnt all 0.
- Reset asserted mid-operation discards all stored and in-flight data. Memory contents are not cleared.

## Timing
- Without bypass: a push accepted at edge E0 gives mem_rd_en high in the following cycle. The address is captured at E1 and the data is loaded into the buffer at E2. p_srdy is high after E2, i.e. 2-cycle latency.
- Steady state with p_drdy=1: one pop per cycle after the initial latency.
- p_drdy=0: the output buffer fills to 2 and reads stop. Memory then absorbs depth words, after which c_drdy drops.
- c_drdy rises the cycle after the first read issue from a full memory.
- p_srdy/p_data are registered. c_drdy and mem_rd_en are combinational from registered state and p_drdy only. c_srdy has no combinational path to p_srdy.

## Configuration
- SD_FIFO_MEMCTL_BYPASS_EN defined: cut-through is enabled.
  - Condition: mem_cnt==0, rd_pend==0 and obuf_cnt - pop < 2.
  - Under that condition a push is written straight into the output buffer. mem_wr_en stays 0 and the pointers do not move.
  - Latency drops to 1: p_srdy is high after E0.
- Macro undefined: every word passes through memory, with 2-cycle latency as above.

## Test plan
- Reset with c_srdy=1 held: all outputs at reset values during reset. First push is on the first cycle after reset deasserts.
- Single word 0x5A into empty FIFO, p_drdy=1:
  - Bypass undefined: p_srdy asserts 2 cycles after accept with p_data=0x5A, and mem_wr_en pulses once.
  - Bypass defined: latency is 1 and mem_wr_en stays 0.
- Fill with p_drdy=0, depth=16, data 0..17: c_drdy drops after 18 accepts and usage=18. Release p_drdy: 0..17 pop in order, with wrptr/rdptr wrap exercised.
- depth=6 with continuous c_srdy=1 and p_drdy=1 for 100 words: one pop per cycle after latency, in order, no drops, and addresses never exceed 5.
- Random c_srdy/p_drdy at 50% for 2000 words against a scoreboard: order is preserved, usage matches the model every cycle, and c_drdy=0 exactly when mem_cnt=16.
- Reset asserted with 10 words stored and a read in flight: next cycle usage=0 and p_srdy=0. New data 0xA1 then pops first.

Source files
------------

// File: rtl/sd_fifo_memctl_if.sv
// sd_fifo_memctl_if: bus bundle for the sd_fifo_memctl FIFO controller.
// Groups the consumer-side (write) handshake, producer-side (read) handshake,
// usage count and the external two-port memory connection.
// slave  : the FIFO controller itself
// master : the surrounding logic (producer/consumer plus the memory)
interface sd_fifo_memctl_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int asz = (depth > 1) ? $clog2(depth) : 1;
  localparam int usz = $clog2(depth + 3);

  // consumer side: words entering the FIFO
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;

  // producer side: words leaving the FIFO
  logic             p_srdy;
  logic             p_drdy;
  logic [width-1:0] p_data;

  logic [usz-1:0]   usage;

  // external memory with registered read address
  logic             mem_wr_en;
  logic [asz-1:0]   mem_wr_addr;
  logic [width-1:0] mem_d_in;
  logic             mem_rd_en;
  logic [asz-1:0]   mem_rd_addr;
  logic [width-1:0] mem_d_out;

  modport slave (
    input  c_srdy, c_data, p_drdy, mem_d_out,
    output c_drdy, p_srdy, p_data, usage,
           mem_wr_en, mem_wr_addr, mem_d_in, mem_rd_en, mem_rd_addr
  );

  modport master (
    output c_srdy, c_data, p_drdy, mem_d_out,
    input  c_drdy, p_srdy, p_data, usage,
           mem_wr_en, mem_wr_addr, mem_d_in, mem_rd_en, mem_rd_addr
  );
endinterface

// File: rtl/sd_fifo_memctl.sv
// sd_fifo_memctl: srdy/drdy FIFO controller driving an external two-port
// memory whose read address is registered (data valid one cycle after the
// address is captured). A two-entry output buffer hides that read latency so
// the producer side can pop one word per cycle.
//
// Optional build macro SD_FIFO_MEMCTL_BYPASS_EN: when defined, a push into an
// otherwise empty pipeline (no words in memory, no read in flight, room in the
// output buffer after this cycle's pop) is written straight into the output
// buffer, cutting latency from 2 cycles to 1. Undefined (default): every word
// goes through memory.
//
// Occupancy bookkeeping:
//   mem_cnt  words written to memory and not yet read out
//   rd_pend  a read address was captured last cycle; mem_d_out is valid now
//   obuf_cnt words in the output buffer (0..2), head drives p_data
// A read is only issued if the buffer is guaranteed to have a free slot when
// the data returns, so the buffer can never overflow.
module sd_fifo_memctl #(
  parameter int width = 8,
  parameter int depth = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  sd_fifo_memctl_if.slave   io_bus
);

  localparam int asz = (depth > 1) ? $clog2(depth) : 1;
  localparam int usz = $clog2(depth + 3);
  localparam int mcw = $clog2(depth + 1);

  localparam logic [asz-1:0] PTR_LAST = asz'(depth - 1);
  localparam logic [mcw-1:0] MEM_FULL = mcw'(depth);

  // registered state
  logic [asz-1:0]   r_wrptr;
  logic [asz-1:0]   r_rdptr;
  logic [mcw-1:0]   r_mem_cnt;
  logic             r_rd_pend;
  logic [1:0]       r_obuf_cnt;
  logic [width-1:0] r_obuf0;
  logic [width-1:0] r_obuf1;

  // combinational helpers
  logic             w_push;
  logic             w_pop;
  logic             w_byp;
  logic             w_mem_push;
  logic             w_rd_issue;
  logic [1:0]       w_obuf_after_pop;
  logic [1:0]       w_obuf_committed;
  logic             w_load;
  logic [width-1:0] w_load_data;
  logic [width-1:0] w_obuf0_nxt;
  logic [width-1:0] w_obuf1_nxt;
  logic [1:0]       w_obuf_cnt_nxt;
  logic [mcw-1:0]   w_mem_cnt_nxt;
  logic [asz-1:0]   w_wrptr_inc;
  logic [asz-1:0]   w_rdptr_inc;

  // Handshakes. Pushes are masked during reset so the memory never sees a
  // write enable while the controller is being cleared.
  assign io_bus.c_drdy = (r_mem_cnt < MEM_FULL);
  assign w_push        = io_bus.c_srdy & io_bus.c_drdy & ~i_reset;
  assign w_pop         = (r_obuf_cnt != 2'd0) & io_bus.p_drdy;

  assign w_obuf_after_pop = r_obuf_cnt - {1'b0, w_pop};
  // slots that will be occupied once any in-flight read has landed
  assign w_obuf_committed = w_obuf_after_pop + {1'b0, r_rd_pend};

`ifdef SD_FIFO_MEMCTL_BYPASS_EN
  // cut-through only when no older word can still be in memory or in flight
  assign w_byp = (r_mem_cnt == '0) & ~r_rd_pend & (w_obuf_after_pop < 2'd2);
`else
  assign w_byp = 1'b0;
`endif

  assign w_mem_push = w_push & ~w_byp;

  // Reads only target words already counted in mem_cnt, so they can never
  // collide with the address being written in the same cycle.
  assign w_rd_issue = (r_mem_cnt != '0) & (w_obuf_committed < 2'd2) & ~i_reset;

  // Data entering the output buffer: returning memory read, or a bypassed
  // push. The two are mutually exclusive because bypass requires !rd_pend.
  assign w_load      = r_rd_pend | (w_push & w_byp);
  assign w_load_data = r_rd_pend ? io_bus.mem_d_out : io_bus.c_data;

  // explicit wrap keeps non-power-of-two depths inside 0..depth-1
  assign w_wrptr_inc = (r_wrptr == PTR_LAST) ? '0 : r_wrptr + 1'b1;
  assign w_rdptr_inc = (r_rdptr == PTR_LAST) ? '0 : r_rdptr + 1'b1;

  // Output buffer next state: shift on pop, then append the loaded word
  // behind whatever remains.
  always_comb begin
    w_obuf0_nxt    = w_pop ? r_obuf1 : r_obuf0;
    w_obuf1_nxt    = r_obuf1;
    w_obuf_cnt_nxt = w_obuf_after_pop;
    if (w_load) begin
      if (w_obuf_after_pop == 2'd0) begin
        w_obuf0_nxt = w_load_data;
      end else begin
        w_obuf1_nxt = w_load_data;
      end
      w_obuf_cnt_nxt = w_obuf_after_pop + 2'd1;
    end
  end

  // Memory occupancy: +1 on a write to memory, -1 on a read issue.
  always_comb begin
    w_mem_cnt_nxt = r_mem_cnt;
    case ({w_mem_push, w_rd_issue})
      2'b10:   w_mem_cnt_nxt = r_mem_cnt + 1'b1;
      2'b01:   w_mem_cnt_nxt = r_mem_cnt - 1'b1;
      default: w_mem_cnt_nxt = r_mem_cnt;
    endcase
  end

  // Pointer and occupancy registers; reset drops all stored and in-flight words.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrptr    <= '0;
      r_rdptr    <= '0;
      r_mem_cnt  <= '0;
      r_rd_pend  <= 1'b0;
      r_obuf_cnt <= 2'd0;
    end else begin
      if (w_mem_push) begin
        r_wrptr <= w_wrptr_inc;
      end
      if (w_rd_issue) begin
        r_rdptr <= w_rdptr_inc;
      end
      r_mem_cnt  <= w_mem_cnt_nxt;
      r_rd_pend  <= w_rd_issue;
      r_obuf_cnt <= w_obuf_cnt_nxt;
    end
  end

  // Output buffer data registers; cleared so p_data reads 0 out of reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_obuf0 <= '0;
      r_obuf1 <= '0;
    end else begin
      r_obuf0 <= w_obuf0_nxt;
      r_obuf1 <= w_obuf1_nxt;
    end
  end

  assign io_bus.p_srdy = (r_obuf_cnt != 2'd0);
  assign io_bus.p_data = r_obuf0;
  assign io_bus.usage  = usz'(r_mem_cnt) + usz'(r_rd_pend) + usz'(r_obuf_cnt);

  assign io_bus.mem_wr_en   = w_mem_push;
  assign io_bus.mem_wr_addr = r_wrptr;
  assign io_bus.mem_d_in    = io_bus.c_data;
  assign io_bus.mem_rd_en   = w_rd_issue;
  assign io_bus.mem_rd_addr = r_rdptr;

endmodule

// File: tb/tb_sd_fifo_memctl.sv
// tb_sd_fifo_memctl: scoreboard bench for sd_fifo_memctl.
// Instance A: depth 16, directed reset/single-word/fill/random/reset tests.
// Instance B: depth 6, continuous streaming.
// Accepted words are queued at the consumer side; monitors pop and compare at
// every producer-side transfer and track expected usage each cycle.
module tb_sd_fifo_memctl;

`ifdef SD_FIFO_MEMCTL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  sd_fifo_memctl_if #(.width(8), .depth(16)) ifa ();
  sd_fifo_memctl_if #(.width(8), .depth(6))  ifb ();

  sd_fifo_memctl #(.width(8), .depth(16)) dut_a (
    .i_clk(clk), .i_reset(reset), .io_bus(ifa.slave));
  sd_fifo_memctl #(.width(8), .depth(6)) dut_b (
    .i_clk(clk), .i_reset(reset), .io_bus(ifb.slave));

  // memory models: write on edge, registered read address
  logic [7:0] mem_a [0:15];
  logic [3:0] ra_q;
  always @(posedge clk) begin
    if (ifa.mem_wr_en) mem_a[ifa.mem_wr_addr] <= ifa.mem_d_in;
    if (ifa.mem_rd_en) ra_q <= ifa.mem_rd_addr;
  end
  assign ifa.mem_d_out = mem_a[ra_q];

  logic [7:0] mem_b [0:7];
  logic [2:0] rb_q;
  always @(posedge clk) begin
    if (ifb.mem_wr_en) mem_b[ifb.mem_wr_addr] <= ifb.mem_d_in;
    if (ifb.mem_rd_en) rb_q <= ifb.mem_rd_addr;
  end
  assign ifb.mem_d_out = mem_b[rb_q];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard queues and usage models
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int model_a = 0;
  int model_b = 0;
  int wr_cnt_a = 0;
  int cyc = 0;
  int b_pops = 0;
  int b_first = -1;
  int b_last = -1;

  // stimulus side of the scoreboard: record every accepted word
  always @(negedge clk) begin
    if (!reset && ifa.c_srdy && ifa.c_drdy) qa.push_back(ifa.c_data);
    if (!reset && ifb.c_srdy && ifb.c_drdy) qb.push_back(ifb.c_data);
  end

  always @(negedge clk) begin
    cyc++;
    if (ifa.mem_wr_en) wr_cnt_a++;
  end

  // monitor A
  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      model_a = 0;
    end else begin
      check("a_usage", ifa.usage, model_a);
      if (model_a == 18) check("a_cdrdy_full", ifa.c_drdy, 0);
      else if (model_a < 16) check("a_cdrdy_room", ifa.c_drdy, 1);
      if (ifa.p_srdy && ifa.p_drdy) begin
        if (qa.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL a_pop_empty: got pop of %0h expected no pop", ifa.p_data);
        end else begin
          check("a_pop_data", ifa.p_data, qa.pop_front());
        end
      end
      model_a = model_a + ((ifa.c_srdy && ifa.c_drdy) ? 1 : 0)
                        - ((ifa.p_srdy && ifa.p_drdy) ? 1 : 0);
    end
  end

  // monitor B
  always @(negedge clk) begin
    if (reset) begin
      qb.delete();
      model_b = 0;
    end else begin
      check("b_usage", ifb.usage, model_b);
      if (ifb.mem_wr_en) check("b_wr_addr_range", (ifb.mem_wr_addr <= 3'd5), 1);
      if (ifb.mem_rd_en) check("b_rd_addr_range", (ifb.mem_rd_addr <= 3'd5), 1);
      if (ifb.p_srdy && ifb.p_drdy) begin
        if (qb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL b_pop_empty: got pop of %0h expected no pop", ifb.p_data);
        end else begin
          check("b_pop_data", ifb.p_data, qb.pop_front());
        end
        if (b_first < 0) b_first = cyc;
        b_last = cyc;
        b_pops++;
      end
      model_b = model_b + ((ifb.c_srdy && ifb.c_drdy) ? 1 : 0)
                        - ((ifb.p_srdy && ifb.p_drdy) ? 1 : 0);
    end
  end

  task automatic drain_a(input string name);
    int k;
    ifa.c_srdy = 1'b0;
    ifa.p_drdy = 1'b1;
    k = 0;
    while (ifa.usage != 0 && k < 60) begin
      tick();
      k++;
    end
    check(name, (ifa.usage == 0), 1);
  endtask

  initial begin
    int n;
    int it;
    int wr_start;
    ifa.c_srdy = 1'b1; ifa.c_data = 8'h5A; ifa.p_drdy = 1'b1;
    ifb.c_srdy = 1'b0; ifb.c_data = 8'h00; ifb.p_drdy = 1'b1;
    reset = 1'b1;

    // reset held with c_srdy=1: outputs at reset values
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_c_drdy", ifa.c_drdy, 1);
      check("rst_p_srdy", ifa.p_srdy, 0);
      check("rst_p_data", ifa.p_data, 0);
      check("rst_usage", ifa.usage, 0);
      check("rst_wr_en", ifa.mem_wr_en, 0);
      check("rst_rd_en", ifa.mem_rd_en, 0);
      check("rst_wr_addr", ifa.mem_wr_addr, 0);
      check("rst_rd_addr", ifa.mem_rd_addr, 0);
    end

    // single word 0x5A, accepted on the first cycle out of reset
    reset = 1'b0;
    wr_start = wr_cnt_a;
    #1;
    check("sw_wr_en", ifa.mem_wr_en, !BYP);
    check("sw_c_drdy", ifa.c_drdy, 1);
    tick();                                  // E0
    ifa.c_srdy = 1'b0;
    #1;
    check("sw_p_srdy_e0", ifa.p_srdy, BYP);
    check("sw_rd_en_e0", ifa.mem_rd_en, !BYP);
`ifdef SD_FIFO_MEMCTL_BYPASS_EN
    check("sw_p_data", ifa.p_data, 8'h5A);
`endif
    tick();                                  // E1
    check("sw_p_srdy_e1", ifa.p_srdy, 0);
    tick();                                  // E2
    check("sw_p_srdy_e2", ifa.p_srdy, !BYP);
`ifndef SD_FIFO_MEMCTL_BYPASS_EN
    check("sw_p_data", ifa.p_data, 8'h5A);
`endif
    tick();
    check("sw_usage_end", ifa.usage, 0);
    check("sw_wr_pulses", wr_cnt_a - wr_start, BYP ? 0 : 1);

    // fill with p_drdy=0, data 0..17
    ifa.p_drdy = 1'b0;
    ifa.c_srdy = 1'b1;
    n = 0; it = 0;
    while (it < 40) begin
      ifa.c_data = n[7:0];
      #1;
      if (!ifa.c_drdy) break;
      n++; it++;
      tick();
    end
    ifa.c_srdy = 1'b0;
    check("fill_accepts", n, 18);
    check("fill_usage", ifa.usage, 18);
    check("fill_c_drdy", ifa.c_drdy, 0);
    check("fill_rd_en_idle", ifa.mem_rd_en, 0);
    tick();
    ifa.p_drdy = 1'b1;
    #1;
    check("full_rd_issue", ifa.mem_rd_en, 1);
    check("full_c_drdy_low", ifa.c_drdy, 0);
    tick();
    check("full_c_drdy_rise", ifa.c_drdy, 1);
    drain_a("fill_drain");
    check("fill_queue_empty", qa.size(), 0);

    // random traffic, 2000 words
    n = 0; it = 0;
    while (n < 2000 && it < 20000) begin
      ifa.c_srdy = 1'($urandom_range(0, 1));
      ifa.p_drdy = 1'($urandom_range(0, 1));
      ifa.c_data = 8'($urandom);
      #1;
      if (ifa.c_srdy && ifa.c_drdy) n++;
      it++;
      tick();
    end
    check("rand_accepts", n, 2000);
    drain_a("rand_drain");
    check("rand_queue_empty", qa.size(), 0);

    // reset mid-operation with words stored and a read in flight
    ifa.p_drdy = 1'b0;
    ifa.c_srdy = 1'b1;
    n = 0; it = 0;
    while (n < 11 && it < 40) begin
      ifa.c_data = 8'h30 + n[7:0];
      #1;
      if (ifa.c_drdy) n++;
      it++;
      tick();
    end
    ifa.c_srdy = 1'b0;
    tick(); tick(); tick();
    check("mr_usage_11", ifa.usage, 11);
    ifa.p_drdy = 1'b1;
    #1;
    check("mr_rd_issue", ifa.mem_rd_en, 1);
    tick();
    ifa.p_drdy = 1'b0;
    reset = 1'b1;
    #1;
    check("mr_usage_10", ifa.usage, 10);
    tick();
    check("mr_usage_rst", ifa.usage, 0);
    check("mr_p_srdy_rst", ifa.p_srdy, 0);
    reset = 1'b0;
    ifa.c_srdy = 1'b1;
    ifa.c_data = 8'hA1;
    ifa.p_drdy = 1'b1;
    tick();
    ifa.c_srdy = 1'b0;
    it = 0;
    while (!ifa.p_srdy && it < 6) begin
      tick();
      it++;
    end
    check("mr_first_valid", ifa.p_srdy, 1);
    check("mr_first_data", ifa.p_data, 8'hA1);
    drain_a("mr_drain");

    // depth 6, continuous flow of 100 words
    ifb.c_srdy = 1'b1;
    ifb.p_drdy = 1'b1;
    n = 0; it = 0;
    while (n < 100 && it < 200) begin
      ifb.c_data = n[7:0];
      #1;
      if (ifb.c_drdy) n++;
      it++;
      tick();
    end
    ifb.c_srdy = 1'b0;
    check("b_accepts", n, 100);
    check("b_no_stall", it, 100);
    it = 0;
    while (ifb.usage != 0 && it < 20) begin
      tick();
      it++;
    end
    check("b_drained", ifb.usage, 0);
    check("b_pops", b_pops, 100);
    check("b_rate", b_last - b_first, 99);
    check("b_queue_empty", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
